// File: rtl/dff_arb_pkg.sv
// Shared types and width helpers for the round-robin register write arbiter.
// Width helpers keep the per-instance localparams tied to the module parameters.
package dff_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    function automatic int own_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic int hold_w(input int max_hold);
        return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
    endfunction

    localparam int N_REQ_DEF    = 4;
    localparam int DATA_W_DEF   = 8;
    localparam int MAX_HOLD_DEF = 4;
    localparam int OWN_W        = own_w(N_REQ_DEF);
    localparam int HOLD_W       = hold_w(MAX_HOLD_DEF);

endpackage

// File: rtl/dff_reg_arbiter_if.sv
// Requester-facing bus of the shared register arbiter: requests, data, grant and register view.
interface dff_reg_arbiter_if
    import dff_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int OWN_W_L = own_w(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        last;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [OWN_W_L-1:0]      owner;
    logic                    busy;
    logic [DATA_W-1:0]       q;
    logic                    q_valid;
    logic                    ack;

    modport master (
        output req, last, wdata,
        input  gnt, owner, busy, q, q_valid, ack
    );

    modport slave (
        input  req, last, wdata,
        output gnt, owner, busy, q, q_valid, ack
    );

endinterface

// File: rtl/dff_reg_arbiter_rr_pick.sv
// Rotating priority encoder: first set request scanning upward from ptr, with wrap.
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = own_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     ptr,
    output logic [W-1:0]     winner,
    output logic             any_req
);

    always_comb begin
        // NOTE: assign every output before the loop so no path leaves it unassigned, which would infer a latch.
        winner  = ptr;
        any_req = |req;
        // Walk from the farthest offset down so the nearest request to ptr is written last and wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) winner = W'(idx);
        end
    end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin owner arbitration in front of one shared DATA_W register; the owner writes one word per clock.
module dff_reg_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input logic               clk,
    input logic               rst,
    dff_reg_arbiter_if.slave  bus
);

    localparam int OW = own_w(N_REQ);
    localparam int HW = hold_w(MAX_HOLD);

    state_t          state;
    logic [OW-1:0]   ptr;
    logic [HW-1:0]   hold_cnt;

    logic [OW-1:0]     winner;
    logic              any_req;
    logic              own_req;
    logic              own_last;
    logic [DATA_W-1:0] own_wdata;
    logic              release_now;
    logic [OW-1:0]     next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .W     (OW)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        own_req     = bus.req[bus.owner];
        own_last    = bus.last[bus.owner];
        own_wdata   = bus.wdata[bus.owner*DATA_W +: DATA_W];
        // Release on req low, on a last hint with a write, or when this write exhausts the hold budget.
        release_now = !own_req || own_last || (hold_cnt == HW'(MAX_HOLD - 1));
        next_ptr    = (bus.owner == OW'(N_REQ - 1)) ? '0 : bus.owner + OW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shared data register is reset too, so q reads zero until the first real write.
            state       <= ST_IDLE;
            bus.gnt     <= '0;
            bus.owner   <= '0;
            bus.busy    <= 1'b0;
            bus.q       <= '0;
            bus.q_valid <= 1'b0;
            bus.ack     <= 1'b0;
            ptr         <= '0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.ack <= 1'b0;
                    if (any_req) begin
                        state     <= ST_OWN;
                        bus.gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                        bus.owner <= winner;
                        bus.busy  <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                ST_OWN: begin
                    if (own_req) begin
                        bus.q       <= own_wdata;
                        bus.q_valid <= 1'b1;
                        bus.ack     <= 1'b1;
                        hold_cnt    <= hold_cnt + HW'(1);
                    end else begin
                        bus.ack <= 1'b0;
                    end
                    if (release_now) begin
                        state    <= ST_IDLE;
                        bus.gnt  <= '0;
                        bus.busy <= 1'b0;
                        ptr      <= next_ptr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
